// File: rtl/rv_core_pkg.sv
// Shared definitions for the multi-cycle RV32I core.
// Fetch FSM encoding, NOP word and default reset vector.
package rv_core_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_VALID = 3'd3,
      S_HALT  = 3'd4
   } fetch_state_t;

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch unit: redirect, advance or hold.
// Purely combinational; the PC register lives in inst_fetch.
module fetch_pc_gen (
   input  logic [31:0] i_pc,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_advance,
   output logic [31:0] o_next_pc
);

   always_comb begin
      o_next_pc = i_pc;
      if (i_redirect)
         o_next_pc = i_redirect_pc & 32'hFFFF_FFFC;
      else if (i_advance)
         o_next_pc = i_pc + 32'd4;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads sync-read imem,
// hands words to the decoder over valid/ready.
module inst_fetch
   import rv_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          ADDR_W   = 12
) (
   input  logic              CLK,
   input  logic              RST,
   output logic              I_MEM_CSN,
   output logic [ADDR_W-1:0] I_MEM_ADDR,
   input  logic [31:0]       I_MEM_DI,
   output logic [31:0]       INST,
   output logic [31:0]       INST_PC,
   output logic              INST_VALID,
   input  logic              INST_READY,
   input  logic              REDIRECT,
   input  logic [31:0]       REDIRECT_PC,
   input  logic              HALT,
   output logic              HALTED,
   output logic [31:0]       INST_CNT
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_inst;
   logic [31:0]  r_inst_pc;
   logic [31:0]  r_cnt;
   logic [31:0]  w_next_pc;
   logic         w_live;
   logic         w_acc;
   logic         w_halt;
   logic         w_redir;
   logic         w_adv;
   logic         w_capture;

   // HALT and REDIRECT only act once fetching has begun
   assign w_live    = (r_state == S_FETCH) || (r_state == S_WAIT)
                   || (r_state == S_VALID);
   assign w_acc     = (r_state == S_VALID) && INST_READY;
   assign w_halt    = HALT && w_live;
   assign w_redir   = REDIRECT && !HALT && w_live;
   assign w_adv     = w_acc && !HALT && !REDIRECT;
   assign w_capture = (r_state == S_WAIT) && !w_halt && !w_redir;

   always_comb begin
      w_next_state = S_IDLE;
      unique case (r_state)
         S_IDLE:  w_next_state = S_FETCH;
         S_FETCH: w_next_state = S_WAIT;
         S_WAIT:  w_next_state = S_VALID;
         S_VALID: w_next_state = w_acc ? S_FETCH : S_VALID;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
      if (w_halt)
         w_next_state = S_HALT;
      else if (w_redir)
         w_next_state = S_FETCH;
   end

   fetch_pc_gen u_pc_gen (
      .i_pc          (r_pc),
      .i_redirect    (w_redir),
      .i_redirect_pc (REDIRECT_PC),
      .i_advance     (w_adv),
      .o_next_pc     (w_next_pc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_inst    <= NOP_INST;
         r_inst_pc <= RESET_PC;
         r_cnt     <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         if (w_acc)
            r_cnt <= r_cnt + 32'd1;
         if (w_capture) begin
            r_inst    <= I_MEM_DI;
            r_inst_pc <= r_pc;
         end
      end
   end

   assign I_MEM_CSN  = (r_state != S_FETCH);
   assign I_MEM_ADDR = r_pc[ADDR_W-1:0];
   assign INST       = r_inst;
   assign INST_PC    = r_inst_pc;
   assign INST_VALID = (r_state == S_VALID);
   assign HALTED     = (r_state == S_HALT);
   assign INST_CNT   = r_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed steps plus random traffic against
// a timeline-based reference model of the fetch unit.
module tb_inst_fetch;
   import rv_core_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, halt = 1'b0, red = 1'b0, rdy = 1'b0;
   logic [31:0] rpc = 32'h0;

   logic        csn0, v0, hd0, csn1, v1, hd1;
   logic [11:0] addr0, addr1;
   logic [31:0] di0 = 32'hDEAD_BEEF, di1 = 32'hDEAD_BEEF;
   logic [31:0] inst0, ipc0, cnt0, inst1, ipc1, cnt1;

   int n_cmp = 0;
   int n_bad = 0;
   int rd0   = 0;

   inst_fetch #(.RESET_PC(32'h0), .ADDR_W(12)) dut0 (
      .CLK(clk), .RST(rst), .I_MEM_CSN(csn0), .I_MEM_ADDR(addr0),
      .I_MEM_DI(di0), .INST(inst0), .INST_PC(ipc0), .INST_VALID(v0),
      .INST_READY(rdy), .REDIRECT(red), .REDIRECT_PC(rpc),
      .HALT(halt), .HALTED(hd0), .INST_CNT(cnt0));

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(12)) dut1 (
      .CLK(clk), .RST(rst), .I_MEM_CSN(csn1), .I_MEM_ADDR(addr1),
      .I_MEM_DI(di1), .INST(inst1), .INST_PC(ipc1), .INST_VALID(v1),
      .INST_READY(rdy), .REDIRECT(red), .REDIRECT_PC(rpc),
      .HALT(halt), .HALTED(hd1), .INST_CNT(cnt1));

   function automatic logic [31:0] memword(input logic [11:0] a);
      case (a)
         12'h000: return 32'h0050_0093;
         12'h004: return 32'h0030_0113;
         12'h008: return 32'h0020_81B3;
         default: return 32'hC0DE_0000 | {20'h0, a};
      endcase
   endfunction

   always @(posedge clk) begin
      if (!csn0) begin
         di0 <= memword(addr0);
         rd0 <= rd0 + 1;
      end
      if (!csn1)
         di1 <= memword(addr1);
   end

   // Model: m_age counts cycles since the current fetch began
   // (-1 = just out of reset, 2+ = instruction on offer).
   logic [31:0] m_pc, m_cnt, m_inst, m_ipc;
   bit          m_halt;
   int          m_age;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [31:0] d);
      bit acc;
      if (rst) begin
         m_pc = 32'h0; m_cnt = 0; m_inst = NOP_INST;
         m_ipc = 32'h0; m_halt = 0; m_age = -1;
      end else if (m_halt) begin
         m_halt = 1;
      end else if (m_age < 0) begin
         m_age = 0;
      end else begin
         acc = (m_age >= 2) && rdy;
         if (halt) begin
            if (acc) m_cnt = m_cnt + 1;
            m_halt = 1;
         end else if (red) begin
            if (acc) m_cnt = m_cnt + 1;
            m_pc  = rpc & 32'hFFFF_FFFC;
            m_age = 0;
         end else if (m_age == 0) begin
            m_age = 1;
         end else if (m_age == 1) begin
            m_inst = d; m_ipc = m_pc; m_age = 2;
         end else if (acc) begin
            m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_age = 0;
         end
      end
   endtask

   task automatic check_all();
      bit ex_v;
      ex_v = (m_age >= 2) && !m_halt;
      chk("csn", {31'b0, csn0}, (m_age == 0 && !m_halt) ? 0 : 1);
      chk("addr", {20'b0, addr0}, {20'b0, m_pc[11:0]});
      chk("valid", {31'b0, v0}, {31'b0, ex_v});
      chk("halted", {31'b0, hd0}, {31'b0, m_halt});
      chk("cnt", cnt0, m_cnt);
      chk("inst", inst0, m_inst);
      chk("inst_pc", ipc0, m_ipc);
      if (ex_v)
         chk("inst_mem", inst0, memword(m_ipc[11:0]));
   endtask

   task automatic step(input bit r, input bit h, input bit rd,
                       input bit ry, input logic [31:0] t);
      logic [31:0] d;
      rst = r; halt = h; red = rd; rdy = ry; rpc = t;
      d = di0;
      @(posedge clk);
      model_edge(d);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [31:0] words [3];
      logic [31:0] hold_inst;
      int          rd_snap;
      words[0] = 32'h0050_0093;
      words[1] = 32'h0030_0113;
      words[2] = 32'h0020_81B3;

      @(negedge clk);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("rst_inst", inst0, NOP_INST);
      chk("rst_valid", {31'b0, v0}, 0);
      chk("rst_csn", {31'b0, csn0}, 1);
      chk("rst_cnt", cnt0, 0);

      // sequential fetch, both instances in lockstep
      for (int k = 1; k <= 9; k++) begin
         step(0, 0, 0, 1, 0);
         if (k % 3 == 0) begin
            chk("seq_valid", {31'b0, v0}, 1);
            chk("seq_pc", ipc0, 32'(k / 3 - 1) * 4);
            chk("seq_inst", inst0, words[k/3-1]);
         end
         if (k == 3) chk("wrap_pc0", ipc1, 32'hFFFF_FFFC);
         if (k == 4) chk("wrap_addr", {20'b0, addr1}, 0);
         if (k == 6) chk("wrap_pc1", ipc1, 32'h0);
      end
      step(0, 0, 0, 1, 0);
      chk("seq_cnt", cnt0, 3);

      // backpressure at PC 0xC
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      hold_inst = inst0;
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 0, 0);
         chk("bp_inst", inst0, hold_inst);
         chk("bp_pc", ipc0, 32'hC);
         chk("bp_csn", {31'b0, csn0}, 1);
      end
      step(0, 0, 0, 1, 0);
      chk("bp_fetch", {31'b0, csn0}, 0);
      chk("bp_addr", {20'b0, addr0}, 12'h010);

      // redirect during WAIT
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 32'h102);
      chk("rw_addr", {20'b0, addr0}, 12'h100);
      chk("rw_csn", {31'b0, csn0}, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rw_pc", ipc0, 32'h100);
      chk("rw_inst", inst0, memword(12'h100));

      // redirect without ready drops, then with ready counts
      step(0, 0, 1, 0, 32'h10);
      chk("rv_drop", cnt0, 4);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rv_pc", ipc0, 32'h10);
      step(0, 0, 1, 1, 32'h40);
      chk("rv_cnt", cnt0, 5);
      chk("rv_addr", {20'b0, addr0}, 12'h040);

      for (int k = 0; k < 300; k++)
         step(0, 0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
              $urandom);

      // HALT wins over REDIRECT
      step(0, 1, 1, 1, 32'h200);
      chk("h_halted", {31'b0, hd0}, 1);
      chk("h_valid", {31'b0, v0}, 0);
      chk("h_csn", {31'b0, csn0}, 1);
      rd_snap = rd0;
      for (int k = 0; k < 20; k++)
         step(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      chk("h_noread", 32'(rd0 - rd_snap), 0);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("h_restart", {20'b0, addr0}, 0);
      chk("h_rcsn", {31'b0, csn0}, 0);

      // counter wrap through forced state
      force dut0.r_cnt = 32'hFFFF_FFFF;
      #1 release dut0.r_cnt;
      m_cnt = 32'hFFFF_FFFF;
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("cnt_wrap", cnt0, 0);

      // reset during an outstanding read
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("mr_inst", inst0, NOP_INST);
      chk("mr_valid", {31'b0, v0}, 0);
      chk("mr_cnt", cnt0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("mr_nop", inst0, NOP_INST);
      step(0, 0, 0, 1, 0);
      chk("mr_fresh", inst0, words[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
